// File: rtl/sad_pe_array.sv
// rtl/sad_pe_array.sv - pipelined handshaked SAD engine over one stored macroblock.
// Optional best-match tracking is built when SAD_BEST_TRACK_EN is defined.
module sad_pe_array #(
  parameter int MACRO_DIM = 16,
  parameter int PIXEL_W   = 8,
  parameter int CAND_W    = 11,
  localparam int SAD_W    = PIXEL_W + 2 * $clog2(MACRO_DIM)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         cur_valid,
  output logic                         cur_ready,
  input  logic [MACRO_DIM*PIXEL_W-1:0] cur_row,
  input  logic                         srch_valid,
  output logic                         srch_ready,
  input  logic [MACRO_DIM*PIXEL_W-1:0] srch_row,
  input  logic                         srch_last,
  output logic                         sad_valid,
  output logic [SAD_W-1:0]             sad_out,
  output logic [CAND_W-1:0]            sad_idx,
  output logic                         best_valid,
  output logic [SAD_W-1:0]             best_sad,
  output logic [CAND_W-1:0]            best_idx
);

  localparam int LOG_W  = $clog2(MACRO_DIM);
  localparam int RS_W   = PIXEL_W + LOG_W;
  localparam int ROW_W  = MACRO_DIM * PIXEL_W;
  localparam logic [LOG_W-1:0] LAST_ROW = LOG_W'(MACRO_DIM - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_READY = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [LOG_W-1:0]  ld_cnt_q, ld_cnt_d;
  logic [LOG_W-1:0]  row_cnt_q, row_cnt_d;
  logic [CAND_W-1:0] cand_cnt_q, cand_cnt_d;
  logic [SAD_W-1:0]  acc_q, acc_d;
  logic              s1_valid_q, s1_valid_d;
  logic              s1_last_q, s1_last_d;
  logic [RS_W-1:0]   row_sum_q, row_sum_d;
  logic              sad_valid_q, sad_valid_d;
  logic [SAD_W-1:0]  sad_out_q, sad_out_d;
  logic [CAND_W-1:0] sad_idx_q, sad_idx_d;
  logic [ROW_W-1:0]  cpr_q [MACRO_DIM];
  logic [ROW_W-1:0]  cpr_d [MACRO_DIM];

  logic              cur_fire, srch_fire, ready_entry, emit;
  logic [RS_W-1:0]   row_sum_c;
  logic [PIXEL_W:0]  diff, absd;
  logic [SAD_W-1:0]  sad_sum;

  assign cur_ready   = (state_q == ST_IDLE) || (state_q == ST_LOAD);
  assign srch_ready  = (state_q == ST_READY);
  assign cur_fire    = cur_valid && cur_ready && !flush;
  assign srch_fire   = srch_valid && srch_ready && !flush;
  assign ready_entry = (state_q == ST_LOAD) && cur_fire && (ld_cnt_q == LAST_ROW);
  assign sad_sum     = acc_q + {{(SAD_W-RS_W){1'b0}}, row_sum_q};
  assign emit        = s1_valid_q && s1_last_q;

  // Stage 1: row SAD against the stored CPR row selected by the row counter.
  always_comb begin
    row_sum_c = '0;
    diff      = '0;
    absd      = '0;
    for (int k = 0; k < MACRO_DIM; k++) begin
      diff      = {1'b0, srch_row[k*PIXEL_W +: PIXEL_W]}
                - {1'b0, cpr_q[row_cnt_q][k*PIXEL_W +: PIXEL_W]};
      absd      = diff[PIXEL_W] ? -diff : diff;
      row_sum_c = row_sum_c + {{LOG_W{1'b0}}, absd[PIXEL_W-1:0]};
    end
  end

  always_comb begin
    cpr_d = cpr_q;
    if (cur_fire) cpr_d[ld_cnt_q] = cur_row;
  end

  always_comb begin
    state_d     = state_q;
    ld_cnt_d    = ld_cnt_q;
    row_cnt_d   = row_cnt_q;
    cand_cnt_d  = cand_cnt_q;
    acc_d       = acc_q;
    s1_valid_d  = srch_fire;
    s1_last_d   = s1_last_q;
    row_sum_d   = row_sum_q;
    sad_valid_d = 1'b0;
    sad_out_d   = sad_out_q;
    sad_idx_d   = sad_idx_q;

    if (s1_valid_q) begin
      if (s1_last_q) begin
        sad_valid_d = 1'b1;
        sad_out_d   = sad_sum;
        sad_idx_d   = cand_cnt_q;
        acc_d       = '0;
        cand_cnt_d  = cand_cnt_q + 1'b1;
      end else begin
        acc_d = sad_sum;
      end
    end

    if (srch_fire) begin
      row_sum_d = row_sum_c;
      s1_last_d = (row_cnt_q == LAST_ROW);
      row_cnt_d = row_cnt_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (cur_fire) begin
          ld_cnt_d = ld_cnt_q + 1'b1;
          state_d  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (cur_fire) begin
          ld_cnt_d = ld_cnt_q + 1'b1;
          if (ld_cnt_q == LAST_ROW) begin
            state_d    = ST_READY;
            row_cnt_d  = '0;
            cand_cnt_d = '0;
          end
        end
      end
      ST_READY: begin
        if (srch_fire && (row_cnt_q == LAST_ROW) && srch_last) state_d = ST_DRAIN;
      end
      default: begin
        if (sad_valid_q) state_d = ST_IDLE;
      end
    endcase

    // Flush drops any concurrent beat; held output data stays, pulses do not fire.
    if (flush) begin
      state_d     = ST_IDLE;
      ld_cnt_d    = '0;
      row_cnt_d   = '0;
      cand_cnt_d  = '0;
      acc_d       = '0;
      s1_valid_d  = 1'b0;
      sad_valid_d = 1'b0;
      sad_out_d   = sad_out_q;
      sad_idx_d   = sad_idx_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ld_cnt_q    <= '0;
      row_cnt_q   <= '0;
      cand_cnt_q  <= '0;
      acc_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      row_sum_q   <= '0;
      sad_valid_q <= 1'b0;
      sad_out_q   <= '0;
      sad_idx_q   <= '0;
      for (int r = 0; r < MACRO_DIM; r++) cpr_q[r] <= '0;
    end else begin
      state_q     <= state_d;
      ld_cnt_q    <= ld_cnt_d;
      row_cnt_q   <= row_cnt_d;
      cand_cnt_q  <= cand_cnt_d;
      acc_q       <= acc_d;
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      row_sum_q   <= row_sum_d;
      sad_valid_q <= sad_valid_d;
      sad_out_q   <= sad_out_d;
      sad_idx_q   <= sad_idx_d;
      for (int r = 0; r < MACRO_DIM; r++) cpr_q[r] <= cpr_d[r];
    end
  end

  assign sad_valid = sad_valid_q;
  assign sad_out   = sad_out_q;
  assign sad_idx   = sad_idx_q;

`ifdef SAD_BEST_TRACK_EN
  logic              s1_final_q, s1_final_d;
  logic              best_first_q, best_first_d;
  logic              best_valid_q, best_valid_d;
  logic [SAD_W-1:0]  best_sad_q, best_sad_d;
  logic [CAND_W-1:0] best_idx_q, best_idx_d;

  // Strict less-than keeps the earlier index on ties.
  always_comb begin
    s1_final_d   = srch_fire ? (srch_last && (row_cnt_q == LAST_ROW)) : s1_final_q;
    best_first_d = best_first_q;
    best_valid_d = 1'b0;
    best_sad_d   = best_sad_q;
    best_idx_d   = best_idx_q;
    if (emit) begin
      if (best_first_q || (sad_sum < best_sad_q)) begin
        best_sad_d = sad_sum;
        best_idx_d = cand_cnt_q;
      end
      best_first_d = 1'b0;
      best_valid_d = s1_final_q;
    end
    if (ready_entry) best_first_d = 1'b1;
    if (flush) begin
      s1_final_d   = 1'b0;
      best_first_d = 1'b0;
      best_valid_d = 1'b0;
      best_sad_d   = '0;
      best_idx_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_final_q   <= 1'b0;
      best_first_q <= 1'b0;
      best_valid_q <= 1'b0;
      best_sad_q   <= '0;
      best_idx_q   <= '0;
    end else begin
      s1_final_q   <= s1_final_d;
      best_first_q <= best_first_d;
      best_valid_q <= best_valid_d;
      best_sad_q   <= best_sad_d;
      best_idx_q   <= best_idx_d;
    end
  end

  assign best_valid = best_valid_q;
  assign best_sad   = best_sad_q;
  assign best_idx   = best_idx_q;
`else
  logic unused_best;
  assign unused_best = ready_entry ^ emit;
  assign best_valid  = 1'b0;
  assign best_sad    = '0;
  assign best_idx    = '0;
`endif

endmodule

// File: tb/tb_sad_pe_array.sv
// tb/tb_sad_pe_array.sv - scoreboard bench for sad_pe_array (default 16x16, 8-bit pixels).
module tb_sad_pe_array;

  localparam int MD = 16;
  localparam int PW = 8;
  localparam int CW = 11;
  localparam int SW = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush;
  logic            cur_valid;
  logic            cur_ready;
  logic [MD*PW-1:0] cur_row;
  logic            srch_valid;
  logic            srch_ready;
  logic [MD*PW-1:0] srch_row;
  logic            srch_last;
  logic            sad_valid;
  logic [SW-1:0]   sad_out;
  logic [CW-1:0]   sad_idx;
  logic            best_valid;
  logic [SW-1:0]   best_sad;
  logic [CW-1:0]   best_idx;

  sad_pe_array dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .cur_valid(cur_valid), .cur_ready(cur_ready), .cur_row(cur_row),
    .srch_valid(srch_valid), .srch_ready(srch_ready), .srch_row(srch_row),
    .srch_last(srch_last),
    .sad_valid(sad_valid), .sad_out(sad_out), .sad_idx(sad_idx),
    .best_valid(best_valid), .best_sad(best_sad), .best_idx(best_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [SW-1:0] sad;
    logic [CW-1:0] idx;
    logic          bvalid;
    logic [SW-1:0] bsad;
    logic [CW-1:0] bidx;
  } exp_t;

  exp_t          sb[$];
  int            tests = 0;
  int            fails = 0;
  int            sv_count = 0;
  int            ld_err = 0;
  int            rd_err = 0;
  logic [7:0]    cpr_m  [MD][MD];
  logic [7:0]    cand_m [MD][MD];
  logic [CW-1:0] exp_idx;
  logic [SW-1:0] b_sad;
  logic [CW-1:0] b_idx;
  bit            b_first;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && sad_valid) begin
      sv_count++;
      if (sb.size() == 0) begin
        check_eq("unexpected_sad_valid", {31'd0, sad_valid}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("sad_out", sad_out, e.sad);
        check_eq("sad_idx", sad_idx, e.idx);
        check_eq("best_valid", best_valid, e.bvalid);
        check_eq("best_sad", best_sad, e.bsad);
        check_eq("best_idx", best_idx, e.bidx);
      end
    end else if (rst_n && best_valid) begin
      check_eq("best_valid_alone", best_valid, 0);
    end
  end

  task automatic load_cpr();
    for (int r = 0; r < MD; r++) begin
      int t = 0;
      for (int k = 0; k < MD; k++) cur_row[k*PW +: PW] = cpr_m[r][k];
      cur_valid = 1'b1;
      while (!cur_ready && t < 50) begin @(posedge clk); #1; t++; end
      if (!cur_ready) check_eq("cur_timeout", cur_ready, 1);
      if (srch_ready) ld_err++;
      @(posedge clk); #1;
    end
    cur_valid = 1'b0;
    exp_idx = '0;
    b_first = 1'b1;
  endtask

  task automatic send_row(input int r, input logic last, input bit gaps);
    int t = 0;
    if (gaps) begin
      while ($urandom_range(0, 2) == 0) begin srch_valid = 1'b0; @(posedge clk); #1; end
    end
    for (int k = 0; k < MD; k++) srch_row[k*PW +: PW] = cand_m[r][k];
    srch_last  = last;
    srch_valid = 1'b1;
    while (!srch_ready && t < 50) begin @(posedge clk); #1; t++; end
    if (!srch_ready) check_eq("srch_timeout", srch_ready, 1);
    if (cur_ready) rd_err++;
    @(posedge clk); #1;
    srch_valid = 1'b0;
    srch_last  = 1'b0;
  endtask

  task automatic run_cand(input bit last, input bit gaps);
    exp_t e;
    int s = 0;
    for (int r = 0; r < MD; r++)
      for (int k = 0; k < MD; k++)
        s += (cand_m[r][k] > cpr_m[r][k]) ? int'(cand_m[r][k]) - int'(cpr_m[r][k])
                                          : int'(cpr_m[r][k]) - int'(cand_m[r][k]);
    e.sad = SW'(s);
    e.idx = exp_idx;
`ifdef SAD_BEST_TRACK_EN
    if (b_first || e.sad < b_sad) begin b_sad = e.sad; b_idx = exp_idx; end
    b_first  = 1'b0;
    e.bvalid = last;
    e.bsad   = b_sad;
    e.bidx   = b_idx;
`else
    e.bvalid = 1'b0;
    e.bsad   = '0;
    e.bidx   = '0;
`endif
    sb.push_back(e);
    exp_idx++;
    for (int r = 0; r < MD; r++) send_row(r, last && (r == MD - 1), gaps);
  endtask

  task automatic fill_cpr(input int mode);
    for (int r = 0; r < MD; r++)
      for (int k = 0; k < MD; k++)
        case (mode)
          0: cpr_m[r][k] = 8'h10;
          1: cpr_m[r][k] = 8'h00;
          2: cpr_m[r][k] = 8'(k);
          default: cpr_m[r][k] = 8'($urandom_range(0, 255));
        endcase
  endtask

  task automatic fill_cand(input int mode);
    for (int r = 0; r < MD; r++)
      for (int k = 0; k < MD; k++)
        case (mode)
          0: cand_m[r][k] = 8'h10;
          1: cand_m[r][k] = 8'hFF;
          2: cand_m[r][k] = 8'(15 - k);
          default: cand_m[r][k] = 8'($urandom_range(0, 255));
        endcase
  endtask

  // Candidate against an all-zero CPR whose SAD is exactly target.
  task automatic fill_cand_target(input int target);
    int rem = target;
    for (int r = 0; r < MD; r++)
      for (int k = 0; k < MD; k++) begin
        cand_m[r][k] = 8'((rem > 255) ? 255 : rem);
        rem -= int'(cand_m[r][k]);
      end
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((sb.size() != 0 || !cur_ready) && t < 100) begin @(posedge clk); #1; t++; end
    if (t >= 100) check_eq("drain_timeout", sb.size(), 0);
  endtask

  initial begin
    int sv_before;
    rst_n = 1'b0; flush = 1'b0; cur_valid = 1'b0; srch_valid = 1'b0; srch_last = 1'b0;
    cur_row = '0; srch_row = '0;
    exp_idx = '0; b_sad = '0; b_idx = '0; b_first = 1'b1;
    #12;
    check_eq("rst_cur_ready", cur_ready, 1);
    check_eq("rst_srch_ready", srch_ready, 0);
    check_eq("rst_sad_valid", sad_valid, 0);
    check_eq("rst_sad_out", sad_out, 0);
    check_eq("rst_sad_idx", sad_idx, 0);
    check_eq("rst_best_valid", best_valid, 0);
    check_eq("rst_best_sad", best_sad, 0);
    check_eq("rst_best_idx", best_idx, 0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;

    // Identical block, latency and drain timing.
    fill_cpr(0); load_cpr();
    fill_cand(0); run_cand(1'b1, 1'b0);
    check_eq("lat_n1_sad_valid", sad_valid, 0);
    check_eq("drain_srch_ready", srch_ready, 0);
    check_eq("drain_cur_ready", cur_ready, 0);
    @(posedge clk); #1;
    check_eq("lat_n2_sad_valid", sad_valid, 1);
    check_eq("lat_n2_sad_out", sad_out, 0);
    @(posedge clk); #1;
    check_eq("idle_cur_ready", cur_ready, 1);
    wait_drain();

    // Maximum difference, then mirrored ramps.
    fill_cpr(1); load_cpr();
    fill_cand(1); sb.push_back('{sad: 16'd65280, idx: 11'd0, bvalid: 1'b0, bsad: '0, bidx: '0});
`ifdef SAD_BEST_TRACK_EN
    sb[0].bvalid = 1'b1; sb[0].bsad = 16'd65280;
`endif
    for (int r = 0; r < MD; r++) send_row(r, r == MD - 1, 1'b0);
    wait_drain();
    fill_cpr(2); load_cpr();
    fill_cand(2); sb.push_back('{sad: 16'd2048, idx: 11'd0, bvalid: 1'b0, bsad: '0, bidx: '0});
`ifdef SAD_BEST_TRACK_EN
    sb[0].bvalid = 1'b1; sb[0].bsad = 16'd2048;
`endif
    for (int r = 0; r < MD; r++) send_row(r, r == MD - 1, 1'b0);
    wait_drain();
    repeat (3) @(posedge clk); #1;
    check_eq("hold_sad_out", sad_out, 2048);

    // Best tracking with a tie.
    fill_cpr(1); load_cpr();
    fill_cand_target(500); run_cand(1'b0, 1'b0);
    fill_cand_target(200); run_cand(1'b0, 1'b0);
    fill_cand_target(200); run_cand(1'b0, 1'b0);
    fill_cand_target(900); run_cand(1'b1, 1'b0);
    wait_drain();
`ifdef SAD_BEST_TRACK_EN
    check_eq("final_best_sad", best_sad, 200);
    check_eq("final_best_idx", best_idx, 1);
`else
    check_eq("final_best_sad", best_sad, 0);
    check_eq("final_best_idx", best_idx, 0);
`endif

    // Random gaps across back-to-back candidates.
    fill_cpr(3); load_cpr();
    for (int c = 0; c < 3; c++) begin
      fill_cand(3); run_cand(c == 2, 1'b1);
    end
    wait_drain();
    check_eq("load_srch_ready_zero", ld_err, 0);
    check_eq("ready_cur_ready_zero", rd_err, 0);

    // Flush on row 7 of candidate 2.
    fill_cpr(3); load_cpr();
    fill_cand(3); run_cand(1'b0, 1'b0);
    fill_cand(3); run_cand(1'b0, 1'b0);
    for (int r = 0; r < 7; r++) send_row(r, 1'b0, 1'b0);
    repeat (3) @(posedge clk); #1;
    check_eq("pre_flush_sb_empty", sb.size(), 0);
    sv_before = sv_count;
    srch_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; srch_valid = 1'b0;
    check_eq("flush_cur_ready", cur_ready, 1);
    check_eq("flush_srch_ready", srch_ready, 0);
    repeat (20) @(posedge clk); #1;
    check_eq("flush_no_sad_valid", sv_count - sv_before, 0);
    load_cpr();
    fill_cand(3); run_cand(1'b1, 1'b0);
    wait_drain();

    // Asynchronous reset on row 9.
    fill_cpr(3); load_cpr();
    fill_cand(3);
    for (int r = 0; r < 9; r++) send_row(r, 1'b0, 1'b0);
    srch_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_cur_ready", cur_ready, 1);
    check_eq("arst_srch_ready", srch_ready, 0);
    check_eq("arst_sad_valid", sad_valid, 0);
    check_eq("arst_sad_out", sad_out, 0);
    check_eq("arst_sad_idx", sad_idx, 0);
    check_eq("arst_best_valid", best_valid, 0);
    check_eq("arst_best_sad", best_sad, 0);
    check_eq("arst_best_idx", best_idx, 0);
    srch_valid = 1'b0;
    repeat (2) @(posedge clk); #1;
    check_eq("arst_hold_sad_out", sad_out, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    fill_cpr(3); load_cpr();
    fill_cand(3); run_cand(1'b0, 1'b0);
    fill_cand(3); run_cand(1'b1, 1'b0);
    wait_drain();
    check_eq("end_sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired tests=%0d", tests);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sad_pe_array.md
# sad_pe_array

Parametrised processing-element array for integer motion estimation. It holds one current macroblock (CPR) and streams candidate blocks from the search region (SPR) row by row. For each candidate it produces a full-block sum of absolute differences (SAD) and a candidate index. It sits between the search-window buffer and the mode-decision logic, and replaces the fixed 16×16 absolute-difference matrix with a pipelined, handshaked SAD engine that has optional best-match tracking.

## Interface
Parameters:
- MACRO_DIM, 16, block edge in pixels (power of two, 4..16)
- PIXEL_W, 8, bits per pixel
- CAND_W, 11, candidate index width
- SAD_W, PIXEL_W+2*$clog2(MACRO_DIM), SAD width (derived, not overridden)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous abort to IDLE
- cur_valid  in  1  CPR row valid
- cur_ready  out  1  CPR row accepted when high with cur_valid
- cur_row  in  MACRO_DIM*PIXEL_W  CPR row, pixel k at [k*PIXEL_W +: PIXEL_W]
- srch_valid  in  1  SPR row valid
- srch_ready  out  1  SPR row accepted when high with srch_valid
- srch_row  in  MACRO_DIM*PIXEL_W  candidate row, same packing
- srch_last  in  1  marks the final candidate; sampled only on a candidate's last row
- sad_valid  out  1  one-cycle pulse, sad_out/sad_idx valid
- sad_out  out  SAD_W  candidate SAD
- sad_idx  out  CAND_W  candidate index (0-based since CPR load)
- best_valid  out  1  one-cycle pulse, best match final
- best_sad  out  SAD_W  minimum SAD over the window
- best_idx  out  CAND_W  index of minimum

## Operation
- FSM: IDLE, LOAD, READY, DRAIN. Reset state is IDLE.
- cur_ready = (IDLE or LOAD). srch_ready = READY.
- IDLE: an accepted cur beat stores row 0 and moves to LOAD.
- LOAD: accepted beats store rows 1..MACRO_DIM-1. On row MACRO_DIM-1: go to READY, clear the candidate counter and row counter.
- READY: each accepted srch beat is row r (counter 0..MACRO_DIM-1, wraps).
  - Stage 1 registers row_sum = Σ|srch_row[k] − cpr[r][k]|, width PIXEL_W+$clog2(MACRO_DIM).
  - Stage 2 accumulates into acc. On r = MACRO_DIM-1, stage 2 emits acc+row_sum on sad_out with sad_idx = candidate counter and pulses sad_valid. It then clears acc and increments the candidate counter.
- Candidate counter wraps modulo 2^CAND_W and does not saturate.
- srch_last on a candidate's last row moves the FSM to DRAIN. srch_last on any other row is ignored.
- DRAIN: lasts until the final sad_valid has been emitted (2 cycles), then returns to IDLE. Rows from the next CPR cannot overlap the old search.
- Absolute difference uses a (PIXEL_W+1)-bit subtract and conditional negate. No arithmetic can overflow SAD_W.
- flush, from any state: returns to IDLE and clears counters, acc, pipeline valids and best registers. Data already registered in outputs is not pulsed.
- Simultaneous flush and handshake: flush wins and the beat is dropped.

## Timing
- Reset values: cur_ready 1, srch_ready 0, sad_valid 0, sad_out 0, sad_idx 0, best_valid 0, best_sad 0, best_idx 0.
- Latency: if a candidate's last row is accepted in cycle N, sad_valid is high in cycle N+2.
- srch_valid may drop between rows. Bubbles only stall the row counter, and results are unaffected.
- Candidates may be streamed back-to-back with no gap: throughput is one row per cycle, one SAD per MACRO_DIM cycles.
- sad_out, sad_idx, best_sad and best_idx hold their values until the next update.
- Asynchronous reset mid-operation: all state and outputs return to reset values immediately.

## Configuration
- SAD_BEST_TRACK_EN defined:
  - On each sad_valid, the running minimum is updated if sad_out < best_sad, or if it is the first candidate.
  - Ties keep the earlier index.
  - best_valid pulses in the same cycle as the final candidate's sad_valid. best_sad and best_idx include that candidate.
  - The running minimum is reset on entry to READY.
- Not defined: best_valid, best_sad and best_idx are tied to 0. No comparator logic is built.

## Test plan
- Defaults. CPR all 0x10, one candidate all 0x10 with srch_last → sad_out 0, sad_idx 0, sad_valid exactly 2 cycles after the last row; FSM back in IDLE 2 cycles later.
- CPR all 0x00, candidate all 0xFF → sad_out 65280. Then CPR pixel = column index, candidate = 15 − column → sad_out 16×128 = 2048.
- With SAD_BEST_TRACK_EN: candidates with SADs 500, 200, 200, 900, the last flagged srch_last → sad_idx 0..3 in order; best_valid with best_sad 200, best_idx 1. Without the macro, best_* stay 0.
- Random srch_valid gaps across 3 back-to-back candidates → SADs equal the gap-free run. srch_ready is 0 throughout LOAD and DRAIN. cur_ready is 0 during READY.
- flush asserted on row 7 of candidate 2 → no further sad_valid, FSM IDLE next cycle, cur_ready 1. Reload and search → sad_idx restarts at 0.
- rst_n low mid-search (row 9) → every output at its reset value while rst_n is low. After release, a full load and search produces correct results.
